// File: rtl/clk_meter_pkg.sv
// Shared types and board constants for the slow-clock meter.
package clk_meter_pkg;

  localparam int unsigned DEF_CNT_W       = 27;
  localparam int unsigned DEF_TIMEOUT_CYC = 100_000_000;
  localparam int unsigned CLK_HZ          = 100_000_000;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    STALLED    = 2'd2
  } state_t;

endpackage

// File: rtl/clk_meter_sync_edge.sv
// Two-flop synchronizer plus a history flop; reports the synchronized level
// and single-cycle rise/fall indications.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   din    : asynchronous input
//   level  : synchronized level (registered)
//   rise_c : synchronized rising edge (combinational from flops)
//   fall_c : synchronized falling edge (combinational from flops)
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic s1;
  logic s2;
  logic prev;

  // Synchronizer chain and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level  = s2;
  assign rise_c = s2 & ~prev;
  assign fall_c = ~s2 & prev;

endmodule

// File: rtl/clk_meter.sv
// Measures period and high time of a slow square wave in clk cycles and
// flags a stalled input.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   sig_in     : asynchronous square wave under measurement
//   edge_pulse : one-cycle strobe per synchronized rising edge
//   period     : clk cycles between the last two rising edges
//   high_time  : clk cycles high within that period
//   meas_valid : one-cycle strobe when period/high_time update
//   timeout    : level, no rising edge for TIMEOUT_CYC cycles
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic level;
  logic rise_c;
  logic fall_c;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hi_lat;
  logic             start_c;
  logic             meas_c;
  logic             stall_c;

  sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sig_in),
    .level  (level),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FIRST;
    else     state <= state_next;
  end

  // Next state; a rise outranks a simultaneous timeout
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    meas_c     = 1'b0;
    stall_c    = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (rise_c) begin
          state_next = RUN;
          start_c    = 1'b1;
        end
      end
      RUN: begin
        if (rise_c) begin
          start_c = 1'b1;
          meas_c  = 1'b1;
        end else if (pcnt == TO_CNT) begin
          state_next = STALLED;
          stall_c    = 1'b1;
        end
      end
      STALLED: begin
        if (rise_c) begin
          state_next = RUN;
          start_c    = 1'b1;
        end
      end
      default: state_next = WAIT_FIRST;
    endcase
  end

  // Period and high-time counters; they only advance while measuring
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      hcnt   <= '0;
      hi_lat <= '0;
    end else if (start_c) begin
      pcnt <= ONE;
      hcnt <= ONE;
    end else if (state == RUN) begin
      if (pcnt != TO_CNT) pcnt <= pcnt + ONE;
      if (level && (hcnt != TO_CNT)) hcnt <= hcnt + ONE;
      if (fall_c) hi_lat <= hcnt;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pulse <= 1'b0;
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      timeout    <= 1'b0;
    end else begin
      edge_pulse <= rise_c;
      meas_valid <= meas_c;
      if (meas_c) begin
        period    <= pcnt;
        high_time <= hi_lat;
      end
      if (stall_c)      timeout <= 1'b1;
      else if (start_c) timeout <= 1'b0;
    end
  end

endmodule
